// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution-engine sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADW = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam int NW_L0       = 9;
    localparam int NW_L1       = 90;
    localparam int N_PIX_DEF   = 784;
    localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/conv_seq_if.sv
// Command, weight/pixel stream, engine and status signals of the sequencer.
interface conv_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_layer;
    logic        abort;
    logic        wbit_valid;
    logic        wbit_ready;
    logic        wbit;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix;
    logic        conv_start;
    logic        conv_state;
    logic        conv_din;
    logic        conv_weight_en;
    logic        conv_weight;
    logic        conv_ovalid;
    logic        conv_done;
    logic [15:0] out_cnt;
    logic        busy;
    logic        irq;
    logic        err_underrun;
    logic        err_timeout;

    // master: buffers/engine/host side; slave: the sequencer itself
    modport master (
        output cmd_valid, cmd_layer, abort, wbit_valid, wbit, pix_valid, pix,
               conv_ovalid, conv_done,
        input  cmd_ready, wbit_ready, pix_ready, conv_start, conv_state, conv_din,
               conv_weight_en, conv_weight, out_cnt, busy, irq, err_underrun, err_timeout
    );

    modport slave (
        input  cmd_valid, cmd_layer, abort, wbit_valid, wbit, pix_valid, pix,
               conv_ovalid, conv_done,
        output cmd_ready, wbit_ready, pix_ready, conv_start, conv_state, conv_din,
               conv_weight_en, conv_weight, out_cnt, busy, irq, err_underrun, err_timeout
    );
endinterface

// File: rtl/conv_seq.sv
// Sequences one layer: weight load, gap-free pixel run, drain, completion irq.
// Latency: cmd accept -> wbit_ready next cycle; last weight -> RUN next cycle; done -> irq next cycle.
// Backpressure: weights may stall via wbit_valid; the pixel stream cannot stall (missing pixels flag underrun).
module conv_seq
    import conv_seq_pkg::*;
#(
    parameter int N_PIX   = conv_seq_pkg::N_PIX_DEF,
    parameter int NW_L0   = conv_seq_pkg::NW_L0,
    parameter int NW_L1   = conv_seq_pkg::NW_L1,
    parameter int TIMEOUT = conv_seq_pkg::TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    conv_seq_if.slave  bus
);

    localparam int PW = $clog2(N_PIX + 1);

    state_t        state;
    logic [6:0]    wcnt;
    logic [PW-1:0] pcnt;
    logic [15:0]   tcnt;
    logic          conv_start_q;
    logic          conv_state_q;
    logic          busy_q;
    logic          irq_q;
    logic [15:0]   out_cnt_q;
    logic          err_underrun_q;
    logic          err_timeout_q;
    logic [6:0]    wlast;

    assign wlast = conv_state_q ? 7'(NW_L1 - 1) : 7'(NW_L0 - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            wcnt           <= '0;
            pcnt           <= '0;
            tcnt           <= '0;
            conv_start_q   <= 1'b0;
            conv_state_q   <= 1'b0;
            busy_q         <= 1'b0;
            irq_q          <= 1'b0;
            out_cnt_q      <= '0;
            err_underrun_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            // Abort beats every other transition, including a same-cycle done
            if (state != ST_IDLE && bus.abort) begin
                state        <= ST_IDLE;
                conv_start_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.cmd_valid) begin
                            state          <= ST_LOADW;
                            conv_state_q   <= bus.cmd_layer;
                            busy_q         <= 1'b1;
                            wcnt           <= '0;
                            pcnt           <= '0;
                            tcnt           <= '0;
                            out_cnt_q      <= '0;
                            err_underrun_q <= 1'b0;
                            err_timeout_q  <= 1'b0;
                        end
                    end
                    ST_LOADW: begin
                        if (bus.wbit_valid) begin
                            wcnt <= wcnt + 7'd1;
                            if (wcnt == wlast) begin
                                state        <= ST_RUN;
                                conv_start_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        pcnt <= pcnt + 1'b1;
                        if (!bus.pix_valid)
                            err_underrun_q <= 1'b1;
                        if (pcnt == PW'(N_PIX - 1))
                            state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        tcnt <= tcnt + 16'd1;
                        if (bus.conv_done) begin
                            state        <= ST_FIN;
                            conv_start_q <= 1'b0;
                            irq_q        <= 1'b1;
                        end else if (tcnt == 16'(TIMEOUT - 1)) begin
                            state         <= ST_FIN;
                            conv_start_q  <= 1'b0;
                            irq_q         <= 1'b1;
                            err_timeout_q <= 1'b1;
                        end
                    end
                    ST_FIN: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state        <= ST_IDLE;
                        conv_start_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
            if ((state == ST_RUN || state == ST_DRAIN) && bus.conv_ovalid && out_cnt_q != 16'hFFFF)
                out_cnt_q <= out_cnt_q + 16'd1;
        end
    end

    // Ready signals decode state only, so the sources never see a valid->ready loop
    assign bus.cmd_ready      = (state == ST_IDLE);
    assign bus.wbit_ready     = (state == ST_LOADW);
    assign bus.pix_ready      = (state == ST_RUN);
    assign bus.conv_weight_en = (state == ST_LOADW) & bus.wbit_valid;
    assign bus.conv_weight    = (state == ST_LOADW) & bus.wbit;
    assign bus.conv_din       = (state == ST_RUN) & bus.pix_valid & bus.pix;

    assign bus.conv_start   = conv_start_q;
    assign bus.conv_state   = conv_state_q;
    assign bus.busy         = busy_q;
    assign bus.irq          = irq_q;
    assign bus.out_cnt      = out_cnt_q;
    assign bus.err_underrun = err_underrun_q;
    assign bus.err_timeout  = err_timeout_q;

endmodule

// File: doc/conv_seq.md
# conv_seq

Sequencer for the binary convolution engine: `conv_mix` and its `conv` and `window` sub-blocks. It accepts one layer command, then streams the layer's bit-serial weights into the engine. It then drives a gap-free pixel stream with `start` held high, counts output-valid pulses, and waits for `done` or a timeout. Completion is reported with a one-cycle `irq`. It sits between the weight/pixel buffers and the engine inside the accelerator top level.

## Interface
Parameters:
- `N_PIX`, 784: pixels streamed per run (28×28).
- `NW_L0`, 9: weight bits for layer 0 (`conv_state`=0).
- `NW_L1`, 90: weight bits for layer 1 (`conv_state`=1).
- `TIMEOUT`, 4096: cycles allowed in DRAIN before error.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_layer` in 1: layer select, latched on command accept.
- `abort` in 1: synchronous abort.
- `wbit_valid` in 1: weight bit available.
- `wbit_ready` out 1: weight bit accepted.
- `wbit` in 1: weight bit.
- `pix_valid` in 1: pixel bit available.
- `pix_ready` out 1: pixel bit accepted.
- `pix` in 1: pixel bit.
- `conv_start` out 1: engine `start`.
- `conv_state` out 1: engine `state` (latched layer).
- `conv_din` out 1: engine `din`.
- `conv_weight_en` out 1: engine `weight_en`.
- `conv_weight` out 1: engine `weight`.
- `conv_ovalid` in 1: engine `ovalid`.
- `conv_done` in 1: engine `done`.
- `out_cnt` out 16: `ovalid` pulses counted this run.
- `busy` out 1: state is not IDLE.
- `irq` out 1: one-cycle completion pulse.
- `err_underrun` out 1: sticky; pixel missing during RUN.
- `err_timeout` out 1: sticky; DRAIN timed out.

## Operation
- States: IDLE, LOADW, RUN, DRAIN, FIN.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_layer` into `conv_state`; clear `out_cnt`, both error flags and all counters; go to LOADW.
- **LOADW**
  - `wbit_ready`=1. `conv_weight_en` = `wbit_valid`; `conv_weight` = `wbit`.
  - The weight counter (7 bits) increments on each accepted bit.
  - The target is `NW_L0` or `NW_L1` according to the latched layer.
  - A cycle with `wbit_valid`=0 is a stall: `weight_en`=0 and no count.
  - The accepting cycle of the last bit moves the FSM to RUN.
- **RUN**
  - `conv_start`=1 and `pix_ready`=1 every cycle.
  - The window shifts every cycle and cannot stall. If `pix_valid`=0, drive `conv_din`=0, set `err_underrun`, and still count the pixel.
  - The pixel counter is clog2(`N_PIX`+1) bits.
  - After the `N_PIX`-th pixel, go to DRAIN.
- **DRAIN**
  - `conv_start` stays 1 and `conv_din`=0.
  - A 16-bit timeout counter increments each cycle.
  - `conv_done`=1 → FIN.
  - Timeout counter reaches `TIMEOUT`−1 → set `err_timeout`, then FIN.
- **FIN**
  - `conv_start`=0 and `irq`=1 for exactly one cycle, then IDLE.
- **Output counting**
  - `out_cnt` increments on each `conv_ovalid` cycle in RUN or DRAIN.
  - It saturates at 0xFFFF and holds its value in IDLE until the next command.
- **Abort**
  - `abort`=1 in any non-IDLE state → IDLE on the next edge.
  - `conv_start` drops and no `irq` is issued. `out_cnt` and the error flags are kept.
  - `abort` in IDLE is ignored.
  - `abort` has priority over every other transition in the same cycle, including `conv_done`.

## Timing
- **Reset values:** all outputs are 0; state is IDLE, so `cmd_ready`=1 after reset.
- **Async reset mid-run:** all outputs, counters and flags return to 0 immediately, without waiting for a clock edge.
- **Registered outputs:** `conv_start`, `conv_state`, `busy`, `irq`, `out_cnt` and the error flags.
- **Same-cycle (combinational) outputs:**
  - `conv_weight_en` and `conv_weight` are valid in the same cycle as the `wbit` handshake.
  - `conv_din` is valid in the same cycle as the `pix` handshake.
  - `wbit_ready` and `pix_ready` are decoded from state only. They never depend on the matching `valid` input.
- **Command latency:** command accepted at edge *t* → `wbit_ready`=1 in cycle *t*+1.
- **LOADW → RUN:** the last weight bit accepted in cycle *c* → `conv_start`=1 and first pixel accepted in cycle *c*+1.
- **Minimum run length (no stalls, immediate `done`):**
  - Layer 0: 1 + 9 + 784 + 1 + 1 cycles from command accept to `irq`.
- **Simultaneous events:**
  - `conv_ovalid` in the same cycle as `conv_done` is counted.
  - `conv_done` during RUN is ignored for state purposes.

## Structure
- **Package `conv_seq_pkg`:**
  - State encoding: IDLE=0, LOADW=1, RUN=2, DRAIN=3, FIN=4; 3-bit type.
  - Constants: `NW_L0`, `NW_L1`, default `N_PIX`, default `TIMEOUT`.
- **Block layout:**
  - Single module with no sub-module; all counters are inline.
  - Integration: a top-level wrapper instantiates `conv_seq` next to `conv_mix` and wires the `conv_*` ports one-to-one.

## Test plan
- **Layer 0 happy path.** Layer-0 command; 9 weight bits 101101001 with no stalls; 784 pixels; engine model gives 676 `ovalid` pulses, then `done` → `conv_weight_en` high exactly 9 cycles; `out_cnt`=676; one `irq`; no errors.
- **Layer 1 with weight stalls.** Layer-1 command; `wbit_valid` low every third cycle → exactly 90 `weight_en` pulses; RUN starts the cycle after the 90th.
- **Pixel underrun.** `pix_valid` low for 3 cycles mid-RUN → `err_underrun`=1; RUN still lasts exactly 784 cycles; `conv_din`=0 in the gap cycles.
- **Timeout.** `conv_done` never asserted; `TIMEOUT`=16 → `err_timeout` set after 16 DRAIN cycles; `irq` pulses once; `cmd_ready` returns.
- **Abort.** `abort` in the same cycle as `conv_done` in DRAIN → IDLE next cycle; no `irq`; `out_cnt` retained.
- **Reset mid-RUN.** `rstn` pulled low asynchronously in RUN → all outputs 0 before the next edge; a new command after release runs normally.
